// File: rtl/midi_encoder.sv
// Transmit-side MIDI event encoder: latches channel-voice and SysEx parameter events,
// then serialises them byte by byte (with running status) toward a UART transmitter.
module midi_encoder #(
    parameter int unsigned RS_REFRESH = 7_500_000,
    parameter logic [7:0]  SX_DEV     = 8'h00
) (
    input  logic       CLOCK_25,
    input  logic       iRST,
    input  logic [3:0] midi_ch,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic [2:0] ev_type,
    input  logic [7:0] ev_d1,
    input  logic [7:0] ev_d2,
    input  logic [2:0] ev_bank,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    localparam int unsigned      CW      = (RS_REFRESH > 2) ? $clog2(RS_REFRESH) : 1;
    localparam logic [CW-1:0]    CNT_MAX = CW'(RS_REFRESH - 1);

    logic          state_q,   state_d;
    logic [2:0]    idx_q,     idx_d;
    logic [2:0]    len_q,     len_d;
    logic          has_st_q,  has_st_d;
    logic [7:0]    last_st_q, last_st_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [7:0]    msg_q [7];
    logic [7:0]    msg_d [7];

    logic       accept;
    logic       xfer;
    logic       st_new;
    logic [3:0] nibble;
    logic [7:0] status;
    logic [7:0] d1m;
    logic [7:0] d2m;

    assign accept   = ev_valid && (state_q == ST_IDLE);
    assign xfer     = (state_q == ST_SEND) && tx_ready;
    assign ev_ready = (state_q == ST_IDLE);
    assign busy     = ~ev_ready;
    assign tx_valid = (state_q == ST_SEND);
    assign tx_byte  = (state_q == ST_SEND) ? msg_q[idx_q] : 8'h00;

    assign d1m    = ev_d1 & 8'h7F;
    assign d2m    = ev_d2 & 8'h7F;
    assign status = {nibble, midi_ch};
    assign st_new = (status != last_st_q);

    always_comb begin
        nibble = 4'h0;
        case (ev_type)
            3'd0:    nibble = 4'h8;
            3'd1:    nibble = 4'h9;
            3'd2:    nibble = 4'hB;
            3'd3:    nibble = 4'hC;
            3'd4:    nibble = 4'hE;
            default: nibble = 4'h0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        has_st_d  = has_st_q;
        last_st_d = last_st_q;
        cnt_d     = cnt_q;
        msg_d     = msg_q;

        if (xfer && (idx_q == 3'd0) && has_st_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Stale running status is dropped only between messages; an accept in the
        // same cycle still compared against last_st_q and may overwrite the clear.
        if ((state_q == ST_IDLE) && (cnt_q == CNT_MAX)) begin
            last_st_d = '0;
        end

        if (accept) begin
            case (ev_type)
                3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
                    if (st_new) begin
                        last_st_d = status;
                        msg_d[0]  = status;
                        msg_d[1]  = d1m;
                        msg_d[2]  = d2m;
                    end else begin
                        msg_d[0]  = d1m;
                        msg_d[1]  = d2m;
                    end
                    if (ev_type == 3'd3) begin
                        len_d = st_new ? 3'd2 : 3'd1;
                    end else begin
                        len_d = st_new ? 3'd3 : 3'd2;
                    end
                    has_st_d = st_new;
                    idx_d    = '0;
                    state_d  = ST_SEND;
                end
                3'd5: begin
                    msg_d[0]  = 8'hF0;
                    msg_d[1]  = 8'h7F;
                    msg_d[2]  = SX_DEV;
                    msg_d[3]  = {5'b0, ev_bank};
                    msg_d[4]  = d1m;
                    msg_d[5]  = d2m;
                    msg_d[6]  = 8'hF7;
                    len_d     = 3'd7;
                    has_st_d  = 1'b0;
                    last_st_d = '0;
                    idx_d     = '0;
                    state_d   = ST_SEND;
                end
                default: ;
            endcase
        end

        if (xfer) begin
            if (idx_q == len_q - 3'd1) begin
                state_d = ST_IDLE;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            has_st_q  <= 1'b0;
            last_st_q <= '0;
            cnt_q     <= '0;
            msg_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            has_st_q  <= has_st_d;
            last_st_q <= last_st_d;
            cnt_q     <= cnt_d;
            msg_q     <= msg_d;
        end
    end

endmodule

// File: tb/tb_midi_encoder.sv
// Directed bench for midi_encoder: byte streams, running status, SysEx,
// backpressure, reserved types, mid-message reset and running-status refresh.
module tb_midi_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] midi_ch;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_type;
    logic [7:0] ev_d1;
    logic [7:0] ev_d2;
    logic [2:0] ev_bank;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  exp_q [$];

    midi_encoder #(
        .RS_REFRESH(16),
        .SX_DEV    (8'h00)
    ) dut (
        .CLOCK_25(clk),
        .iRST    (rst),
        .midi_ch (midi_ch),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_type (ev_type),
        .ev_d1   (ev_d1),
        .ev_d2   (ev_d2),
        .ev_bank (ev_bank),
        .tx_byte (tx_byte),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
        end
    endtask

    // Entered just after a negedge; returns at the negedge following reset release.
    task automatic do_reset();
        rst      = 1'b1;
        tx_ready = 1'b1;
        ev_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check("rst_ev_ready", {7'b0, ev_ready}, 8'h01);
        check("rst_tx_byte",  tx_byte,          8'h00);
        check("rst_busy",     {7'b0, busy},     8'h00);
        rst = 1'b0;
    endtask

    // Presents one event in the low phase and lets the next rising edge accept it.
    task automatic send(input string tag, input logic [2:0] t, input logic [3:0] ch,
                        input logic [7:0] d1, input logic [7:0] d2, input logic [2:0] bank);
        ev_type  = t;
        midi_ch  = ch;
        ev_d1    = d1;
        ev_d2    = d2;
        ev_bank  = bank;
        ev_valid = 1'b1;
        check({tag, "_ready"}, {7'b0, ev_ready}, 8'h01);
        @(posedge clk);
        #1 ev_valid = 1'b0;
        ev_d1 = 8'hxx;
        ev_d2 = 8'hxx;
    endtask

    // Expects exp_q on consecutive cycles starting the cycle after accept, then idle.
    task automatic expect_stream(input string tag);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check($sformatf("%s_v%0d", tag, i), {7'b0, tx_valid}, 8'h01);
            check($sformatf("%s_b%0d", tag, i), tx_byte, exp_q[i]);
            @(posedge clk);
        end
        @(negedge clk);
        check({tag, "_end_valid"}, {7'b0, tx_valid}, 8'h00);
        check({tag, "_end_ready"}, {7'b0, ev_ready}, 8'h01);
    endtask

    initial begin
        rst = 1'b1; tx_ready = 1'b1; ev_valid = 1'b0;
        midi_ch = 4'h0; ev_type = 3'd0; ev_d1 = 8'h00; ev_d2 = 8'h00; ev_bank = 3'd0;
        @(negedge clk);

        do_reset();
        send("non1", 3'd1, 4'h3, 8'h3C, 8'h64, 3'd0);
        exp_q = '{8'h93, 8'h3C, 8'h64}; expect_stream("non1");
        send("non2", 3'd1, 4'h3, 8'h40, 8'h50, 3'd0);
        exp_q = '{8'h40, 8'h50};        expect_stream("non2");
        send("rsv6", 3'd6, 4'h3, 8'h11, 8'h22, 3'd0);
        @(negedge clk);
        check("rsv6_valid", {7'b0, tx_valid}, 8'h00);
        send("non3", 3'd1, 4'h3, 8'h3C, 8'h64, 3'd0);
        exp_q = '{8'h3C, 8'h64};        expect_stream("non3");

        do_reset();
        send("pc1", 3'd3, 4'h3, 8'h05, 8'h00, 3'd0);
        exp_q = '{8'hC3, 8'h05};        expect_stream("pc1");
        send("pb", 3'd4, 4'h3, 8'h00, 8'h40, 3'd0);
        exp_q = '{8'hE3, 8'h00, 8'h40}; expect_stream("pb");
        send("pc2", 3'd3, 4'h3, 8'h06, 8'h00, 3'd0);
        exp_q = '{8'hC3, 8'h06};        expect_stream("pc2");

        do_reset();
        send("sx_a", 3'd1, 4'h3, 8'h3C, 8'h64, 3'd0);
        exp_q = '{8'h93, 8'h3C, 8'h64}; expect_stream("sx_a");
        send("sx", 3'd5, 4'h3, 8'h11, 8'hFF, 3'd2);
        exp_q = '{8'hF0, 8'h7F, 8'h00, 8'h02, 8'h11, 8'h7F, 8'hF7}; expect_stream("sx");
        send("sx_b", 3'd1, 4'h3, 8'h3C, 8'h00, 3'd0);
        exp_q = '{8'h93, 8'h3C, 8'h00}; expect_stream("sx_b");

        // Stall after the first CC byte while a second event is held valid.
        do_reset();
        send("bp", 3'd2, 4'h0, 8'h07, 8'h7F, 3'd0);
        ev_type = 3'd1; ev_d1 = 8'h3C; ev_d2 = 8'h64; ev_valid = 1'b1; tx_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold_b%0d", c),  tx_byte,          8'hB0);
            check($sformatf("bp_hold_v%0d", c),  {7'b0, tx_valid}, 8'h01);
            check($sformatf("bp_hold_rdy%0d", c), {7'b0, ev_ready}, 8'h00);
        end
        tx_ready = 1'b1;
        ev_valid = 1'b0;
        @(posedge clk);
        exp_q = '{8'h07, 8'h7F};        expect_stream("bp_tail");

        do_reset();
        send("ab", 3'd1, 4'h5, 8'h3C, 8'h64, 3'd0);
        @(negedge clk);
        check("ab_first", tx_byte, 8'h95);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ab_valid", {7'b0, tx_valid}, 8'h00);
        check("ab_ready", {7'b0, ev_ready}, 8'h01);
        send("ab2", 3'd1, 4'h5, 8'h3C, 8'h64, 3'd0);
        exp_q = '{8'h95, 8'h3C, 8'h64}; expect_stream("ab2");

        do_reset();
        send("rf1", 3'd1, 4'h0, 8'hBC, 8'hE4, 3'd0);
        exp_q = '{8'h90, 8'h3C, 8'h64}; expect_stream("rf1");
        repeat (20) @(negedge clk);
        send("rf2", 3'd1, 4'h0, 8'hBC, 8'hE4, 3'd0);
        exp_q = '{8'h90, 8'h3C, 8'h64}; expect_stream("rf2");
        repeat (5) @(negedge clk);
        send("rf3", 3'd1, 4'h0, 8'hBC, 8'hE4, 3'd0);
        exp_q = '{8'h3C, 8'h64};        expect_stream("rf3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/midi_encoder.md
# midi_encoder

Transmit-side MIDI event encoder. It accepts channel-voice events and single-parameter SysEx writes from the synth control logic. It serialises them into a MIDI byte stream, with running status, for a UART transmitter. Its output uses the same byte formats that the synthesizer's MIDI decoder parses: note on/off, control change, program change, pitch bend, and the universal-realtime `F0 7F` parameter write. This lets a second synth, or a loopback, be driven from this one.

## Interface
- `RS_REFRESH`, default 7_500_000: idle cycles after the last transmitted status byte before running status is dropped (300 ms at 25 MHz). Minimum value is 2.
- `SX_DEV`, default 8'h00: device byte inserted after `7F` in SysEx writes.

Ports:
- `CLOCK_25` in 1: single clock; every register is clocked on its rising edge.
- `iRST` in 1: synchronous, active-high reset.
- `midi_ch` in 4: transmit channel, sampled at event accept.
- `ev_valid` in 1: event request.
- `ev_ready` out 1: encoder can accept an event.
- `ev_type` in 3: 0 note off, 1 note on, 2 control change, 3 program change, 4 pitch bend (d1 = LSB, d2 = MSB), 5 SysEx parameter write, 6–7 reserved.
- `ev_d1` in 8: key, controller number, program, bend LSB, or SysEx address.
- `ev_d2` in 8: velocity, controller value, bend MSB, or SysEx data.
- `ev_bank` in 3: SysEx bank address; used only when type is 5.
- `tx_byte` out 8: byte to the UART transmitter.
- `tx_valid` out 1: `tx_byte` is valid.
- `tx_ready` in 1: UART accepts the byte.
- `busy` out 1: a message is in flight; equals `~ev_ready`.

## Operation
- Handshakes are valid/ready. A transfer happens on any cycle where both valid and ready are 1.
- On event accept, the message bytes are latched into a 7-entry buffer `buf[0..6]` together with a length `len`. All inputs may change after the accept cycle.
- Data bytes are masked to 7 bits (`& 7'h7F`). The status byte is `{type_nibble, midi_ch}`, with type nibbles 8, 9, B, C, E.
- Running status:
  - Register `last_st` (8 bits; 0 means none).
  - For types 0–4, the status byte is omitted if it equals `last_st`; otherwise it is emitted and `last_st` is updated.
- Message lengths with status byte / without status byte:
  - Types 0, 1, 2, 4: 3 bytes / 2 bytes.
  - Type 3: 2 bytes / 1 byte.
- Type 5 always emits 7 bytes: `F0 7F SX_DEV {5'b0,bank} adr data F7`. Acceptance of a type 5 event clears `last_st` to 0.
- Types 6–7 are accepted in one cycle, emit nothing, and leave `last_st` unchanged.
- State machine:
  - IDLE: `ev_ready`=1, `tx_valid`=0. On accept of types 0–5, go to SEND with `idx`=0. On accept of types 6–7, stay in IDLE.
  - SEND: `tx_valid`=1 and `tx_byte`=`buf[idx]`. On a transfer with `idx`=`len`-1, go to IDLE; on any other transfer, increment `idx`.
- Refresh counter:
  - Reset to 0 whenever a status byte (types 0–4) is transferred.
  - Otherwise increments, saturating at `RS_REFRESH`-1.
  - When it reaches `RS_REFRESH`-1, `last_st` is cleared to 0.
  - If clearing and an accept fall on the same cycle, the accept compares against the pre-clear value.
  - Clearing applies only while no message is in flight.
- Event type 1 with d2=0 is sent as note-on velocity 0. It is not converted to note off.

## Timing
- Reset values: `tx_valid`=0, `tx_byte`=8'h00, `ev_ready`=1, `busy`=0, `last_st`=0, refresh counter 0, `idx`=0, state IDLE.
- Reset mid-message aborts the message. The partial byte stream is not completed.
- Latency:
  - Accept in cycle N puts the first byte on `tx_byte` with `tx_valid`=1 in cycle N+1.
  - With `tx_ready` held at 1, one byte transfers per cycle.
  - `ev_ready` returns to 1 in the cycle after the last transfer.
  - Throughput, back-to-back at full rate: `len`+1 cycles per event.
- While `tx_valid`=1 and `tx_ready`=0, `tx_byte` is held stable. `tx_valid` never drops before the transfer.
- `ev_ready` is 0 from the cycle after accept until the cycle after the final transfer. A held `ev_valid` is not consumed during that time.
- `tx_ready` is ignored in IDLE.

## Test plan
- Reset with `tx_ready`=1 and `ev_valid`=0 for 5 cycles → `tx_valid`=0, `ev_ready`=1, `tx_byte`=00.
- `midi_ch`=3; note on d1=3C d2=64, then note on d1=40 d2=50 → bytes `93 3C 64`, then `40 50` (running status).
- `midi_ch`=3; program change d1=05, then pitch bend d1=00 d2=40, then program change d1=06 → `C3 05`, `E3 00 40`, `C3 06`.
- `midi_ch`=3; note on 3C/64, then SysEx bank=2 adr=11 data=FF, then note on 3C/00 → `93 3C 64`, `F0 7F 00 02 11 7F F7`, `93 3C 00`.
- Backpressure: `tx_ready` low for 10 cycles after the first byte of a CC event (d1=07 d2=7F, ch 0) → `tx_byte`=B0 held, a second `ev_valid` is not accepted, and the stream completes as `B0 07 7F`.
- With `RS_REFRESH`=16: note on d1=BC d2=E4, idle 20 cycles, then the same event → `90 3C 64`, then `90 3C 64` again (status resent). Repeating with a 5-cycle gap → `3C 64` only.
